// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider
// Brief    : Multi-channel run-time programmable clock divider (clkin / 2*DIV)
//            with per-channel tick strobe and glitch-free divide updates.
// Revision : 1.0
// ============================================================================
module prog_clock_divider #(
    parameter int          N_CH        = 2,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 100000000,
    localparam int         CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [N_CH-1:0]   clkout,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pending
);

    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DEF_DIV = CNT_W'(DEFAULT_DIV);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_active;
        logic [CNT_W-1:0] r_shadow;
        logic             r_clkout;
        logic             r_tick;
        logic             r_pending;

        logic             w_wr_hit;
        logic             w_stall;
        logic             w_wrap;
        logic             w_load;
        logic [CNT_W-1:0] w_next_div;

        // Out-of-range channel numbers never match any i, so such writes are dropped.
        always_comb begin
            w_wr_hit   = wr_en && (wr_ch == CH_W'(i));
            w_stall    = (r_active == '0);
            w_wrap     = en[i] && !w_stall && (r_cnt >= (r_active - C_ONE));
            w_load     = !en[i] || w_stall || w_wrap;
            w_next_div = w_wr_hit ? wr_data : r_shadow;
        end

        always_ff @(posedge clkin or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt     <= '0;
                r_active  <= C_DEF_DIV;
                r_shadow  <= C_DEF_DIV;
                r_clkout  <= 1'b0;
                r_tick    <= 1'b0;
                r_pending <= 1'b0;
            end else begin
                // Idle, stalled and wrap cycles are the only safe points to swap divide value;
                // a same-cycle write bypasses the shadow so it is never lost.
                if (w_load) begin
                    r_active  <= w_next_div;
                    r_shadow  <= w_next_div;
                    r_pending <= 1'b0;
                end else if (w_wr_hit) begin
                    r_shadow  <= wr_data;
                    r_pending <= 1'b1;
                end

                if (!en[i] || w_stall) begin
                    r_cnt    <= '0;
                    r_clkout <= 1'b0;
                    r_tick   <= 1'b0;
                end else if (w_wrap) begin
                    r_cnt    <= '0;
                    r_clkout <= ~r_clkout;
                    r_tick   <= 1'b1;
                end else begin
                    r_cnt    <= r_cnt + C_ONE;
                    r_tick   <= 1'b0;
                end
            end
        end

        assign clkout[i]  = r_clkout;
        assign tick[i]    = r_tick;
        assign pending[i] = r_pending;
    end

endmodule
`default_nettype wire
